t_sync_counter: RTL and testbench
=================================

Name: t_sync_counter

Overview:
- Synchronous up/down counter built from per-bit T flip-flop cells.
- Directly consumes the toggle-cell behaviour: the block computes a per-bit T vector each cycle and feeds it to WIDTH toggle cells.
- Provides a modulo-(MAX_VAL+1) count, a parallel load, and terminal-count/wrap status.
- Downstream of it: clock dividers and event counters in the flip-flop/sequential library.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL (MAX_VAL ≤ 2**WIDTH-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; counting occurs only when high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- d  in  WIDTH  load value.
- q  out  WIDTH  registered count.
- t_vec  out  WIDTH  per-bit toggle vector applied this cycle (combinational; observability).
- tc  out  1  terminal count (combinational).
- wrap  out  1  registered one-cycle pulse after a wrap.

Behaviour:
- Reset (rst=0, asynchronous): q=0, wrap=0, all cells cleared. While held: t_vec=0 and tc=0.
- Release: first count edge is the first rising clk with rst=1.
- next_q priority, highest first:
  - load=1 → next_q = min(d, MAX_VAL). en and up are ignored.
  - en=1, up=1 → next_q = (q==MAX_VAL) ? 0 : q+1.
  - en=1, up=0 → next_q = (q==0) ? MAX_VAL : q-1.
  - otherwise → next_q = q.
- t_vec = q XOR next_q. Bit i of cell i toggles on the edge iff t_vec[i]=1. Cell outputs form q.
- Latency: q reflects a request on the same rising edge at which load/en is sampled (1 cycle).
- tc = en & ~load & ((up & q==MAX_VAL) | (~up & q==0)).
- wrap: registered tc. It is 1 for exactly one cycle after each wrap edge and 0 otherwise.
- Out-of-range q (only reachable if MAX_VAL < 2**WIDTH-1 and corrupted): next up-count goes to 0; down-count goes to q-1.
- Simultaneous load and tc condition: load wins, tc=0, wrap=0 next cycle.
- Direction change mid-count: takes effect on the next edge; no extra cycle.
- rst asserted mid-count: q clears immediately, independent of clk. A pending wrap pulse is cancelled.
- en=0 and load=0: t_vec=0, q holds indefinitely.

Optional Feature:
- Macro: T_COUNTER_SAT_EN.
- Defined: saturating mode.
  - up at MAX_VAL → next_q = MAX_VAL.
  - down at 0 → next_q = 0.
  - t_vec=0 in both cases.
  - tc still asserts at the limit; wrap is tied to 0.
- Undefined: modulo wrap as above.

Decomposition:
- Package t_counter_pkg holds:
  - direction constants DIR_UP=1'b1, DIR_DOWN=1'b0.
  - a default-width localparam.
  - a function for clamped next-value computation, shared with the bench model.
- Sub-module t_cell, instantiated WIDTH times:
  - one T flip-flop with async active-low reset.
  - ports clk, rst, t, q.
  - q toggles on rising clk when t=1.

Test Plan (WIDTH=4, MAX_VAL=9 unless noted):
- Reset: rst=0 for 3 cycles with en=1, up=1 → q=0, wrap=0 throughout. Deasserting rst then counts 1,2,3 on successive edges.
- Up wrap: load d=7, then en=1, up=1 for 4 cycles:
  - q sequence 8,9,0,1.
  - tc=1 while q=9.
  - wrap=1 only in the cycle q=0.
  - t_vec=4'b1001 at the 9→0 edge.
- Down wrap: load d=1, then en=1, up=0 → q sequence 0,9,8. wrap pulses once in the cycle after 0→9.
- Load priority and clamp: load=1 with d=4'hF, en=1, up=1 → q=9 (not 0). tc stays 0 while load=1.
- Async reset mid-count: q=6, drop rst between edges → q=0 before the next clk edge. Holding en=0 afterwards keeps q=0 and t_vec=0.
- Full range and saturation: MAX_VAL=15, counting up from 14 → 15, 0 with wrap. Same run with T_COUNTER_SAT_EN → 15, 15, wrap stays 0.

Source files
------------

// File: rtl/t_counter_pkg.sv
// t_counter_pkg: shared direction constants, default width and next-count rule for the T-cell counter.
package t_counter_pkg;
   localparam int DEF_WIDTH = 4;
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   // Out-of-range q counts up to 0 (or clamps when saturating) and down to q-1.
   function automatic logic [31:0] next_count(input logic [31:0] q, input logic [31:0] d,
                                              input logic [31:0] max_val, input logic en,
                                              input logic up, input logic load, input logic sat);
      next_count = load ? ((d > max_val) ? max_val : d)
                 : !en ? q
                 : (up == DIR_UP) ? ((q >= max_val) ? (sat ? max_val : 32'd0) : q + 32'd1)
                 : (up == DIR_DOWN && q == 32'd0) ? (sat ? 32'd0 : max_val)
                 : q - 32'd1;
   endfunction
endpackage

// File: rtl/t_cell.sv
// t_cell: single T flip-flop with asynchronous active-low reset.
module t_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= 1'b0;
      else if (t) q <= ~q;
endmodule

// File: rtl/t_sync_counter.sv
// t_sync_counter: modulo-(MAX_VAL+1) up/down counter built from T cells, with load and tc/wrap status.
// Define T_COUNTER_SAT_EN for saturating limits instead of wrapping.
module t_sync_counter
   import t_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MAX_VAL = 2**WIDTH - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] t_vec,
   output logic             tc,
   output logic             wrap
);
`ifdef T_COUNTER_SAT_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif
   localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MAX_VAL);
   logic [WIDTH-1:0] next_q;
   // Toggle vector is forced quiet while reset holds the cells cleared.
   always_comb begin
      next_q = WIDTH'(next_count(32'(q), 32'(d), 32'(MAX_VAL), en, up, load, SAT));
      t_vec  = rst ? (q ^ next_q) : '0;
      tc     = rst & en & ~load & ((up == DIR_UP) ? (q == MAXQ) : (q == '0));
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_cell u_cell (.clk(clk), .rst(rst), .t(t_vec[i]), .q(q[i]));
   end
`ifdef T_COUNTER_SAT_EN
   assign wrap = 1'b0;
`else
   always_ff @(posedge clk or negedge rst)
      if (!rst) wrap <= 1'b0;
      else wrap <= tc;
`endif
endmodule

// File: tb/tb_t_sync_counter.sv
// tb_t_sync_counter: scoreboard bench driving MAX_VAL=9 and MAX_VAL=15 counters with directed and random stimulus.
module tb_t_sync_counter;
`ifdef T_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0;
   logic [3:0] d = 4'd0;
   logic [3:0] q9, tv9, q15, tv15;
   logic tc9, w9, tc15, w15;
   typedef struct {int id; int q; int tv; bit tc; bit wrap;} exp_t;
   exp_t sb[$];
   int mq[2] = '{0, 0};
   int mw[2] = '{0, 0};
   int mx[2] = '{9, 15};
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   t_sync_counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .q(q9), .t_vec(tv9), .tc(tc9), .wrap(w9));
   t_sync_counter #(.WIDTH(4), .MAX_VAL(15)) dut15 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .q(q15), .t_vec(tv15), .tc(tc15), .wrap(w15));

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: expected outputs for the cycle just driven, then the post-edge state.
   task automatic model(input bit r, input bit e, input bit u, input bit l, input int dv);
      for (int i = 0; i < 2; i++) begin
         exp_t x;
         int nq;
         bit t;
         if (!r) begin
            mq[i] = 0;
            mw[i] = 0;
         end
         if (l) nq = (dv > mx[i]) ? mx[i] : dv;
         else if (!e) nq = mq[i];
         else if (u) nq = (mq[i] >= mx[i]) ? (SAT ? mx[i] : 0) : mq[i] + 1;
         else nq = (mq[i] == 0) ? (SAT ? 0 : mx[i]) : mq[i] - 1;
         t = r && e && !l && (u ? (mq[i] == mx[i]) : (mq[i] == 0));
         x = '{i, mq[i], r ? (mq[i] ^ nq) : 0, t, mw[i] != 0};
         sb.push_back(x);
         if (r) begin
            mq[i] = nq;
            mw[i] = (!SAT && t) ? 1 : 0;
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit u, input bit l, input int dv,
                       input int tvx = -1, input int tcx = -1, input int qx = -1);
      rst = r; en = e; up = u; load = l; d = 4'(dv);
      model(r, e, u, l, dv);
      if (tvx >= 0 || tcx >= 0 || qx >= 0) begin
         #3;
         if (tvx >= 0) chk("tvec_peek", int'(tv9), tvx);
         if (tcx >= 0) chk("tc_peek", int'(tc9), tcx);
         if (qx >= 0) chk("q_peek", int'(q9), qx);
      end
      @(negedge clk);
   endtask

   initial forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         if (x.id == 0) begin
            chk("q9", int'(q9), x.q);
            chk("tvec9", int'(tv9), x.tv);
            chk("tc9", int'(tc9), int'(x.tc));
            chk("wrap9", int'(w9), int'(x.wrap));
         end else begin
            chk("q15", int'(q15), x.q);
            chk("tvec15", int'(tv15), x.tv);
            chk("tc15", int'(tc15), int'(x.tc));
            chk("wrap15", int'(w15), int'(x.wrap));
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      @(negedge clk);
      repeat (3) begin
         step(0, 1, 1, 0, 0);
         chk("rst_q", int'(q9), 0);
         chk("rst_wrap", int'(w9), 0);
      end
      for (int k = 1; k <= 3; k++) begin
         step(1, 1, 1, 0, 0);
         chk("release_q", int'(q9), k);
      end
      step(1, 1, 1, 1, 7);
      chk("load7", int'(q9), 7);
      step(1, 1, 1, 0, 0);
      chk("up_q8", int'(q9), 8);
      step(1, 1, 1, 0, 0);
      chk("up_q9", int'(q9), 9);
      step(1, 1, 1, 0, 0, SAT ? 0 : 9, 1);
      chk("up_wrap_q", int'(q9), SAT ? 9 : 0);
      chk("up_wrap_pulse", int'(w9), SAT ? 0 : 1);
      step(1, 1, 1, 0, 0);
      chk("up_after_q", int'(q9), SAT ? 9 : 1);
      chk("up_wrap_clear", int'(w9), 0);
      step(1, 1, 0, 1, 1);
      step(1, 1, 0, 0, 0);
      chk("down_q0", int'(q9), 0);
      chk("down_nowrap", int'(w9), 0);
      step(1, 1, 0, 0, 0);
      chk("down_wrap_q", int'(q9), SAT ? 0 : 9);
      chk("down_wrap_pulse", int'(w9), SAT ? 0 : 1);
      step(1, 1, 0, 0, 0);
      chk("down_after_q", int'(q9), SAT ? 0 : 8);
      chk("down_wrap_clear", int'(w9), 0);
      step(1, 1, 1, 1, 15, -1, 0);
      chk("load_clamp", int'(q9), 9);
      step(1, 1, 1, 1, 9, -1, 0);
      chk("load_tc_wrap", int'(w9), 0);
      step(1, 0, 0, 1, 5);
      step(1, 1, 1, 0, 0);
      chk("mid_q6", int'(q9), 6);
      step(0, 1, 1, 0, 0, 0, 0, 0);
      repeat (3) begin
         step(1, 0, 0, 0, 0, 0, -1, 0);
         chk("hold_q", int'(q9), 0);
      end
      step(1, 1, 1, 1, 14);
      step(1, 1, 1, 0, 0);
      chk("full_q15", int'(q15), 15);
      step(1, 1, 1, 0, 0);
      chk("full_next", int'(q15), SAT ? 15 : 0);
      chk("full_wrap", int'(w15), SAT ? 0 : 1);
      repeat (400)
         step($urandom_range(31) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom_range(7) == 0, int'($urandom_range(15)));
      #3;
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
